// File: rtl/param_dp_pkg.sv
// Shared definitions for the parametrised datapath.
//   alu_func_e : ALU operation codes driven on alu_func
//   pc_ctrl_e  : PC update codes driven on pc_ctrl
//   Flag*      : bit positions inside the 4-bit {Z,N,C,V} flags word
package param_dp_pkg;

  typedef enum logic [2:0] {
    AluAdd = 3'b000,
    AluSub = 3'b001,
    AluAnd = 3'b010,
    AluOr  = 3'b011,
    AluXor = 3'b100,
    AluNot = 3'b101,
    AluShl = 3'b110,
    AluMov = 3'b111
  } alu_func_e;

  typedef enum logic [1:0] {
    PcHold = 2'b00,
    PcInc  = 2'b01,
    PcRel  = 2'b10,
    PcLoad = 2'b11
  } pc_ctrl_e;

  localparam int unsigned FlagZ = 3;
  localparam int unsigned FlagN = 2;
  localparam int unsigned FlagC = 1;
  localparam int unsigned FlagV = 0;

endpackage

// File: rtl/param_dp_alu.sv
// Combinational DW-wide ALU with {Z,N,C,V} flag generation.
// Ports:
//   a, b    : operands (A = register, B = register or sign-extended immediate)
//   func    : operation code (alu_func_e)
//   flags   : {Z,N,C,V}, present only when DP_FLAGS_EN is defined
//   result  : DW-bit wrap-around result
// Configuration macro: DP_FLAGS_EN (enables the flags port and its logic).
module param_dp_alu
  import param_dp_pkg::*;
#(
  parameter int unsigned DW = 16
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [2:0]    func,
`ifdef DP_FLAGS_EN
  output logic [3:0]    flags,
`endif
  output logic [DW-1:0] result
);

  always_comb begin
    result = '0;
    unique case (alu_func_e'(func))
      AluAdd:  result = a + b;
      AluSub:  result = a - b;
      AluAnd:  result = a & b;
      AluOr:   result = a | b;
      AluXor:  result = a ^ b;
      AluNot:  result = ~a;
      AluShl:  result = {a[DW-2:0], 1'b0};
      AluMov:  result = b;
      default: result = '0;
    endcase
  end

`ifdef DP_FLAGS_EN
  always_comb begin
    flags        = '0;
    flags[FlagZ] = (result == '0);
    flags[FlagN] = result[DW-1];
    unique case (alu_func_e'(func))
      AluAdd: begin
        // A wrapped sum is smaller than either operand exactly when it carried out.
        flags[FlagC] = (result < a);
        flags[FlagV] = (a[DW-1] == b[DW-1]) && (result[DW-1] != a[DW-1]);
      end
      AluSub: begin
        flags[FlagC] = (a < b);
        flags[FlagV] = (a[DW-1] != b[DW-1]) && (result[DW-1] != a[DW-1]);
      end
      AluShl:  flags[FlagC] = a[DW-1];
      default: ;
    endcase
  end
`endif

endmodule

// File: rtl/param_data_path.sv
// Parametrised datapath: PC unit, NREG x DW register file, operand mux and ALU,
// organised as a 3-stage pipeline (read / operand / execute+writeback).
// Ports:
//   clk, rst         : clock (rising edge) and asynchronous active-low reset
//   en_pc, pc_ctrl   : PC update strobe and op (hold, +1, +sext(offset), load zext(offset))
//   offset           : immediate / branch offset
//   en_in            : issue strobe, accepted only while ready=1
//   rd, rs           : destination/operand-A and operand-B register indices
//   alu_in_sel       : 0 selects reg[rs] as B, 1 selects sext(offset)
//   alu_func         : ALU op (alu_func_e)
//   ready            : combinational, low while a RAW/WAW hazard blocks issue
//   en_out, wb_data  : writeback pulse and written value
//   flags            : {Z,N,C,V} of last writeback
//   pc_out           : current program counter
// Configuration macro: DP_FLAGS_EN (flags register; tied to zero when undefined).
module param_data_path
  import param_dp_pkg::*;
#(
  parameter  int unsigned DW   = 16,
  parameter  int unsigned NREG = 4,
  parameter  int unsigned OFFW = 8,
  parameter  int unsigned PCW  = 16,
  localparam int unsigned RW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en_pc,
  input  logic [1:0]      pc_ctrl,
  input  logic [OFFW-1:0] offset,
  input  logic            en_in,
  input  logic [RW-1:0]   rd,
  input  logic [RW-1:0]   rs,
  input  logic            alu_in_sel,
  input  logic [2:0]      alu_func,
  output logic            ready,
  output logic            en_out,
  output logic [DW-1:0]   wb_data,
  output logic [3:0]      flags,
  output logic [PCW-1:0]  pc_out
);

  // ---------------------------------------------------------------- PC unit
  logic [PCW-1:0] pc_q, pc_d;

  always_comb begin
    pc_d = pc_q;
    if (en_pc) begin
      unique case (pc_ctrl_e'(pc_ctrl))
        PcHold:  pc_d = pc_q;
        PcInc:   pc_d = pc_q + PCW'(1);
        PcRel:   pc_d = pc_q + PCW'($signed(offset));
        PcLoad:  pc_d = PCW'(offset);
        default: pc_d = pc_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pc_q <= '0;
    else      pc_q <= pc_d;
  end

  assign pc_out = pc_q;

  // ------------------------------------------------- register file and pipe
  logic [DW-1:0]   regs_q [NREG];

  logic            s1_valid_q, s2_valid_q, s3_valid_q;
  logic [RW-1:0]   s1_rd_q, s2_rd_q, s3_rd_q;
  logic [2:0]      s1_func_q, s2_func_q, s3_func_q;
  logic            s1_sel_q;
  logic [OFFW-1:0] s1_off_q;
  logic [DW-1:0]   s1_a_q, s1_b_q, s2_a_q, s2_b_q, s3_a_q, s3_b_q;

  logic            en_out_q;
  logic [DW-1:0]   wb_data_q;
  logic [DW-1:0]   alu_result;

  logic            s1_hit, s2_hit, accept;
  logic            byp_rd, byp_rs;
  logic [DW-1:0]   rd_val, rs_val;

  // Only S1/S2 can hold a conflicting op; an S3 producer is bypassed below.
  always_comb begin
    s1_hit = s1_valid_q && ((s1_rd_q == rd) || (!alu_in_sel && (s1_rd_q == rs)));
    s2_hit = s2_valid_q && ((s2_rd_q == rd) || (!alu_in_sel && (s2_rd_q == rs)));
  end

  assign ready  = !(s1_hit || s2_hit);
  assign accept = en_in && ready;

  // S3 writes on the same edge S1 reads, so forward its result.
  assign byp_rd = s3_valid_q && (s3_rd_q == rd);
  assign byp_rs = s3_valid_q && (s3_rd_q == rs);
  assign rd_val = byp_rd ? alu_result : regs_q[rd];
  assign rs_val = byp_rs ? alu_result : regs_q[rs];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NREG; i++) regs_q[i] <= '0;
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s3_valid_q <= 1'b0;
      s1_rd_q    <= '0;
      s2_rd_q    <= '0;
      s3_rd_q    <= '0;
      s1_func_q  <= '0;
      s2_func_q  <= '0;
      s3_func_q  <= '0;
      s1_sel_q   <= 1'b0;
      s1_off_q   <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s2_a_q     <= '0;
      s2_b_q     <= '0;
      s3_a_q     <= '0;
      s3_b_q     <= '0;
      en_out_q   <= 1'b0;
      wb_data_q  <= '0;
    end else begin
      // S1: operand read
      s1_valid_q <= accept;
      if (accept) begin
        s1_rd_q   <= rd;
        s1_func_q <= alu_func;
        s1_sel_q  <= alu_in_sel;
        s1_off_q  <= offset;
        s1_a_q    <= rd_val;
        s1_b_q    <= rs_val;
      end
      // S2: B operand select
      s2_valid_q <= s1_valid_q;
      s2_rd_q    <= s1_rd_q;
      s2_func_q  <= s1_func_q;
      s2_a_q     <= s1_a_q;
      s2_b_q     <= s1_sel_q ? DW'($signed(s1_off_q)) : s1_b_q;
      // S3: execute operands
      s3_valid_q <= s2_valid_q;
      s3_rd_q    <= s2_rd_q;
      s3_func_q  <= s2_func_q;
      s3_a_q     <= s2_a_q;
      s3_b_q     <= s2_b_q;
      // Writeback
      en_out_q   <= s3_valid_q;
      if (s3_valid_q) begin
        regs_q[s3_rd_q] <= alu_result;
        wb_data_q       <= alu_result;
      end
    end
  end

  assign en_out  = en_out_q;
  assign wb_data = wb_data_q;

  // ---------------------------------------------------------------- ALU
`ifdef DP_FLAGS_EN
  logic [3:0] alu_flags;
  logic [3:0] flags_q;
`endif

  param_dp_alu #(
    .DW(DW)
  ) u_alu (
    .a      (s3_a_q),
    .b      (s3_b_q),
    .func   (s3_func_q),
`ifdef DP_FLAGS_EN
    .flags  (alu_flags),
`endif
    .result (alu_result)
  );

`ifdef DP_FLAGS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            flags_q <= '0;
    else if (s3_valid_q) flags_q <= alu_flags;
  end

  assign flags = flags_q;
`else
  assign flags = 4'b0000;
`endif

endmodule

// File: tb/tb_param_data_path.sv
// Self-checking bench for param_data_path: directed scenarios plus randomized
// issue/PC traffic compared against a reference model that tracks in-flight
// ops by their due writeback edge. Honors DP_FLAGS_EN like the design.
module tb_param_data_path;

  localparam int unsigned DW   = 16;
  localparam int unsigned NREG = 4;
  localparam int unsigned OFFW = 8;
  localparam int unsigned PCW  = 16;
  localparam int unsigned RW   = $clog2(NREG);

`ifdef DP_FLAGS_EN
  localparam bit FlagsOn = 1'b1;
`else
  localparam bit FlagsOn = 1'b0;
`endif

  localparam int FAdd = 0, FSub = 1, FAnd = 2, FOr = 3, FXor = 4, FNot = 5, FShl = 6, FMov = 7;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            en_pc = 1'b0;
  logic [1:0]      pc_ctrl = '0;
  logic [OFFW-1:0] offset = '0;
  logic            en_in = 1'b0;
  logic [RW-1:0]   rd = '0;
  logic [RW-1:0]   rs = '0;
  logic            alu_in_sel = 1'b0;
  logic [2:0]      alu_func = '0;
  logic            ready;
  logic            en_out;
  logic [DW-1:0]   wb_data;
  logic [3:0]      flags;
  logic [PCW-1:0]  pc_out;

  param_data_path #(
    .DW(DW), .NREG(NREG), .OFFW(OFFW), .PCW(PCW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en_pc      (en_pc),
    .pc_ctrl    (pc_ctrl),
    .offset     (offset),
    .en_in      (en_in),
    .rd         (rd),
    .rs         (rs),
    .alu_in_sel (alu_in_sel),
    .alu_func   (alu_func),
    .ready      (ready),
    .en_out     (en_out),
    .wb_data    (wb_data),
    .flags      (flags),
    .pc_out     (pc_out)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------- reference model
  typedef struct {
    int            due;
    int            dst;
    logic [DW-1:0] res;
    logic [3:0]    fl;
  } pend_t;

  pend_t         pend[$];
  logic [DW-1:0] m_regs [NREG];
  int            m_pc = 0;
  int            edge_n = 0;
  logic          exp_en = 1'b0;
  logic [DW-1:0] exp_wb = '0;
  logic [3:0]    exp_fl = '0;

  localparam longint M  = longint'(1) << DW;
  localparam int     PM = 1 << PCW;

  function automatic int sext_off(input int off);
    return (off >= (1 << (OFFW - 1))) ? off - (1 << OFFW) : off;
  endfunction

  function automatic logic [DW-1:0] sext_dw(input int off);
    return DW'(sext_off(off));
  endfunction

  function automatic void ref_alu(input int f, input logic [DW-1:0] a, input logic [DW-1:0] b,
                                  output logic [DW-1:0] r, output logic [3:0] fl);
    longint ua, ub, sa, sb, full, sfull;
    logic   c, v;
    ua = longint'(a);
    ub = longint'(b);
    sa = a[DW-1] ? ua - M : ua;
    sb = b[DW-1] ? ub - M : ub;
    c  = 1'b0;
    v  = 1'b0;
    r  = '0;
    case (f)
      FAdd: begin
        full  = ua + ub;
        r     = DW'(full);
        c     = (full >= M);
        sfull = sa + sb;
        v     = (sfull >= M / 2) || (sfull < -(M / 2));
      end
      FSub: begin
        full  = ua - ub;
        r     = DW'(full);
        c     = (ua < ub);
        sfull = sa - sb;
        v     = (sfull >= M / 2) || (sfull < -(M / 2));
      end
      FAnd: r = a & b;
      FOr:  r = a | b;
      FXor: r = a ^ b;
      FNot: r = ~a;
      FShl: begin
        r = DW'(ua * 2);
        c = (ua >= M / 2);
      end
      default: r = b;
    endcase
    fl = {(r == '0), r[DW-1], c, v};
    if (!FlagsOn) fl = 4'b0000;
  endfunction

  // Blocked if an op accepted earlier writes at a later edge than the next one.
  function automatic logic model_ready(input int d, input int s, input logic sel);
    foreach (pend[i]) begin
      if (pend[i].due > edge_n + 1 && (pend[i].dst == d || (!sel && pend[i].dst == s)))
        return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_edge(input logic acc, input int f, input int d, input int s,
                            input logic sel, input int off, input logic epc, input int pcc);
    logic [DW-1:0] a, b, r;
    logic [3:0]    fl;
    edge_n++;
    exp_en = 1'b0;
    for (int i = pend.size() - 1; i >= 0; i--) begin
      if (pend[i].due == edge_n) begin
        m_regs[pend[i].dst] = pend[i].res;
        exp_en = 1'b1;
        exp_wb = pend[i].res;
        exp_fl = pend[i].fl;
        pend.delete(i);
      end
    end
    if (acc) begin
      a = m_regs[d];
      b = sel ? sext_dw(off) : m_regs[s];
      ref_alu(f, a, b, r, fl);
      pend.push_back('{due: edge_n + 3, dst: d, res: r, fl: fl});
    end
    if (epc) begin
      case (pcc)
        1:       m_pc = (m_pc + 1) % PM;
        2:       m_pc = (m_pc + sext_off(off) + PM) % PM;
        3:       m_pc = off;
        default: ;
      endcase
    end
  endtask

  task automatic model_clear();
    pend.delete();
    for (int i = 0; i < NREG; i++) m_regs[i] = '0;
    m_pc   = 0;
    exp_en = 1'b0;
    exp_wb = '0;
    exp_fl = '0;
  endtask

  // ----------------------------------------------------------------- stimulus
  // Entered and left at a falling edge.
  task automatic cycle(input logic i_en, input int f, input int d, input int s, input logic sel,
                       input int off, input logic epc, input int pcc, output logic acc);
    logic exp_rdy;
    en_in      = i_en;
    alu_func   = 3'(f);
    rd         = RW'(d);
    rs         = RW'(s);
    alu_in_sel = sel;
    offset     = OFFW'(off);
    en_pc      = epc;
    pc_ctrl    = 2'(pcc);
    #1;
    exp_rdy = model_ready(d, s, sel);
    check("ready", 32'(ready), 32'(exp_rdy));
    @(posedge clk);
    acc = i_en && exp_rdy;
    model_edge(acc, f, d, s, sel, off, epc, pcc);
    @(negedge clk);
    check("en_out", 32'(en_out), 32'(exp_en));
    check("wb_data", 32'(wb_data), 32'(exp_wb));
    check("flags", 32'(flags), 32'(exp_fl));
    check("pc_out", 32'(pc_out), 32'(m_pc));
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int k = 0; k < n; k++) cycle(1'b0, 0, 0, 0, 1'b0, 0, 1'b0, 0, acc);
  endtask

  task automatic pc_op(input int pcc, input int off);
    logic acc;
    cycle(1'b0, 0, 0, 0, 1'b0, off, 1'b1, pcc, acc);
  endtask

  // Holds en_in until the op is accepted; reports how many cycles it stalled.
  task automatic issue(input int f, input int d, input int s, input logic sel, input int off,
                       output int stalls);
    logic acc;
    acc    = 1'b0;
    stalls = 0;
    for (int k = 0; k < 8; k++) begin
      cycle(1'b1, f, d, s, sel, off, 1'b0, 0, acc);
      if (acc) break;
      stalls++;
    end
    if (!acc) check("issue_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    en_in = 1'b0;
    en_pc = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("rst_en_out", 32'(en_out), 32'd0);
    check("rst_pc", 32'(pc_out), 32'd0);
    check("rst_wb", 32'(wb_data), 32'd0);
    check("rst_flags", 32'(flags), 32'd0);
    model_clear();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int   st;
    int   cnt;
    logic acc;

    model_clear();
    @(negedge clk);
    @(negedge clk);
    check("init_en_out", 32'(en_out), 32'd0);
    check("init_pc", 32'(pc_out), 32'd0);
    check("init_wb", 32'(wb_data), 32'd0);
    check("init_flags", 32'(flags), 32'd0);
    check("init_ready", 32'(ready), 32'd1);
    rst = 1'b1;

    // MOV r1,#0x7F then dependent ADD r1,r1
    issue(FMov, 1, 0, 1'b1, 8'h7F, st);
    issue(FAdd, 1, 1, 1'b0, 0, st);
    check("raw_stall_cycles", 32'(st), 32'd2);
    idle(3);
    check("mov_add_en", 32'(en_out), 32'd1);
    check("mov_add_wb", 32'(wb_data), 32'h00FE);
    check("mov_add_flags", 32'(flags), 32'd0);

    // MOV r0,#0x80 sign-extends; SUB r0,r0 gives zero
    issue(FMov, 0, 0, 1'b1, 8'h80, st);
    issue(FSub, 0, 0, 1'b0, 0, st);
    check("mov_sext_wb", 32'(wb_data), 32'hFF80);
    check("mov_sext_flags", 32'(flags), FlagsOn ? 32'h4 : 32'h0);
    idle(3);
    check("sub_zero_wb", 32'(wb_data), 32'h0000);
    check("sub_zero_flags", 32'(flags), FlagsOn ? 32'h8 : 32'h0);

    // Four independent MOVs back-to-back
    for (int i = 0; i < 4; i++) begin
      issue(FMov, i, 0, 1'b1, i + 1, st);
      check("b2b_no_stall", 32'(st), 32'd0);
    end
    cnt = int'(en_out);
    for (int i = 0; i < 4; i++) begin
      idle(1);
      cnt += int'(en_out);
    end
    check("b2b_pulses", 32'(cnt), 32'd4);

    // PC unit
    pc_op(3, 5);
    check("pc_load5", 32'(pc_out), 32'd5);
    pc_op(2, 8'hFE);
    check("pc_rel_back", 32'(pc_out), 32'd3);
    pc_op(0, 8'h33);
    check("pc_hold", 32'(pc_out), 32'd3);
    pc_op(3, 8'h80);
    check("pc_load_zext", 32'(pc_out), 32'h0080);
    pc_op(3, 0);
    pc_op(2, 8'hFF);
    check("pc_rel_wrap", 32'(pc_out), 32'hFFFF);
    pc_op(1, 0);
    check("pc_inc_wrap", 32'(pc_out), 32'd0);

    // Reset while an ADD is in flight
    pc_op(3, 8'h42);
    issue(FAdd, 0, 1, 1'b0, 0, st);
    idle(1);
    do_reset();
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      idle(1);
      cnt += int'(en_out);
    end
    check("rst_discard", 32'(cnt), 32'd0);
    for (int i = 0; i < NREG; i++) begin
      issue(FOr, i, i, 1'b0, 0, st);
      idle(3);
      check("rst_reg_en", 32'(en_out), 32'd1);
      check("rst_reg_zero", 32'(wb_data), 32'd0);
    end

    // 0x7FFF + 1 via 0xFF80 << 8 then NOT
    issue(FMov, 2, 0, 1'b1, 8'h80, st);
    for (int i = 0; i < 8; i++) issue(FShl, 2, 0, 1'b1, 0, st);
    issue(FNot, 2, 0, 1'b1, 0, st);
    issue(FAdd, 2, 0, 1'b1, 1, st);
    idle(3);
    check("ovf_wb", 32'(wb_data), 32'h8000);
    check("ovf_flags", 32'(flags), FlagsOn ? 32'h5 : 32'h0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 599) == 0) do_reset();
      cycle($urandom_range(0, 9) < 7, int'($urandom_range(0, 7)),
            int'($urandom_range(0, NREG - 1)), int'($urandom_range(0, NREG - 1)),
            1'($urandom_range(0, 1)), int'($urandom_range(0, 255)),
            $urandom_range(0, 3) == 0, int'($urandom_range(0, 3)), acc);
    end
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
